multicycle_main_control: RTL and testbench
==========================================

// Module: multicycle_main_control
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. It is the producer side of the ALUOp
//  interface: it decodes the instruction opcode, walks the multicycle state sequence, and
//  drives alu_op (decoded downstream with funct into the 4-bit ALU operation) plus all
//  datapath enables. It waits on a memory-ready handshake for every memory access.
// PARAMETERS
//  MEM_WAIT_EN  1  1: FETCH/MEMRD/MEMWR hold until mem_ready=1; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk          in   1  single clock, rising edge
//  reset        in   1  synchronous, active-high
//  opcode       in   6  instr[31:26] from instruction register (valid from DECODE onward)
//  mem_ready    in   1  memory completes current access this cycle
//  pc_write     out  1  unconditional PC load
//  branch       out  1  PC load if ALU zero
//  iord         out  1  memory address select: 0=PC, 1=ALUOut
//  mem_write    out  1  memory write request
//  ir_write     out  1  instruction register load
//  reg_dst      out  1  write reg: 0=rt, 1=rd
//  mem_to_reg   out  1  write data: 0=ALUOut, 1=MDR
//  reg_write    out  1  register file write
//  alu_src_a    out  1  0=PC, 1=A
//  alu_src_b    out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
//  alu_op       out  2  00=add, 01=sub, 10=use funct
//  pc_src       out  2  00=ALU result, 01=ALUOut, 10=jump target
//  instr_done   out  1  1-cycle pulse in the final cycle of each instruction
//  illegal_op   out  1  1-cycle pulse on unknown opcode in DECODE
// BEHAVIOUR
//  - Reset: state<=FETCH; while reset=1, all outputs are forced to 0. First post-reset cycle is FETCH.
//  - Moore outputs are decoded from state only. Exceptions: ir_write/pc_write in FETCH, and
//    reg/PC side-effects of memory states, are qualified by mem_ready.
//  - Outputs not listed for a state are 0.
//    FETCH    : iord=0, src_a=0, src_b=01, alu_op=00, pc_src=00; ir_write=pc_write=mem_ready. Leaves on mem_ready -> DECODE.
//    DECODE   : src_a=0, src_b=11, alu_op=00. Next-state decode:
//               LW 100011 / SW 101011 -> MEMADR, R 000000 -> EXECUTE, BEQ 000100 -> BRANCH,
//               ADDI 001000 -> ADDIEX, J 000010 -> JUMP; else illegal_op=1 and -> FETCH.
//    MEMADR   : src_a=1, src_b=10, alu_op=00 -> MEMRD (LW) / MEMWR (SW); opcode is sampled in this state.
//    MEMRD    : iord=1; hold until mem_ready -> MEMWB.
//    MEMWB    : reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1 -> FETCH.
//    MEMWR    : iord=1, mem_write=1 held for the whole wait; instr_done=mem_ready; on mem_ready -> FETCH.
//    EXECUTE  : src_a=1, src_b=00, alu_op=10 -> ALUWB.
//    ALUWB    : reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1 -> FETCH.
//    BRANCH   : src_a=1, src_b=00, alu_op=01, pc_src=01, branch=1, instr_done=1 -> FETCH.
//    ADDIEX   : src_a=1, src_b=10, alu_op=00 -> ADDIWB.
//    ADDIWB   : reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1 -> FETCH.
//    JUMP     : pc_src=10, pc_write=1, instr_done=1 -> FETCH.
//  - Latency with zero wait states: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3 cycles. Each cycle with
//    mem_ready=0 in FETCH/MEMRD/MEMWR adds exactly one cycle and repeats that state's outputs unchanged.
//  - In states that do not wait, mem_ready is ignored.
//  - reset asserted mid-instruction overrides everything: there are no partial writes in that cycle
//    (outputs are 0), and the next cycle is FETCH.
//  - Unreachable state encodings -> FETCH next cycle, with all outputs 0 in that cycle.
//  - alu_op=11 is never driven.
// STRUCTURE
//  - Shared package/header mips_ctrl_pkg: 4-bit state encodings, opcode constants, ALUOp codes
//    (ALUOP_ADD/SUB/FUNCT), alu_src_b and pc_src select codes. These are shared with the ALU control decoder.
//  - Sub-module mc_ctrl_decode: purely combinational state -> control-word table.
//    The top level holds the state register, next-state logic and mem_ready qualification.
// TESTING
//  - Reset held 3 cycles, then released with mem_ready=1 -> outputs are 0 during reset; first
//    cycle has ir_write=pc_write=1, src_b=01, alu_op=00.
//  - LW (100011), mem_ready=1 throughout -> FETCH,DECODE,MEMADR,MEMRD,MEMWB. instr_done is high
//    only in cycle 5, with mem_to_reg=1 and reg_write=1.
//  - SW with mem_ready low for 2 cycles in MEMWR -> mem_write high for 3 cycles, instr_done only on
//    the 3rd, then FETCH.
//  - R-type (000000) then BEQ (000100) -> EXECUTE drives alu_op=10; ALUWB has reg_dst=1. BRANCH drives
//    alu_op=01, branch=1, pc_src=01; total 4+3 cycles.
//  - ADDI (001000) then J (000010) -> ADDIEX src_b=10; ADDIWB reg_write=1, reg_dst=0; JUMP pc_src=10, pc_write=1.
//  - Opcode 111111 in DECODE -> illegal_op pulses once, next state FETCH. Reset asserted during MEMRD
//    wait -> FETCH after release, with no reg_write seen.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode, ALUOp and mux-select codes for the multicycle MIPS control
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALUOp codes consumed by the downstream ALU control decoder; 2'b11 is never driven
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Raw per-state control word; mem_gate marks states whose side effects wait on mem_ready
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       mem_gate;
  } ctrl_word_t;

  function automatic logic is_known_opcode(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_main_control_if.sv
// rtl/multicycle_main_control_if.sv - opcode/memory handshake in, datapath control word out
interface multicycle_main_control_if;

  logic [5:0] opcode;
  logic       mem_ready;

  logic       pc_write;
  logic       branch;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational state to raw control-word table
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t cw
);

  // One row per state; anything not named stays 0, unreachable encodings give all zeros
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.iord      = 1'b0;
        cw.alu_src_a = 1'b0;
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALUOP_ADD;
        cw.pc_src    = PCSRC_ALU;
        cw.ir_write  = 1'b1;
        cw.pc_write  = 1'b1;
        cw.mem_gate  = 1'b1;
      end
      S_DECODE: begin
        cw.alu_src_a = 1'b0;
        cw.alu_src_b = SRCB_IMM_SH2;
        cw.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        cw.iord = 1'b1;
      end
      S_MEMWB: begin
        cw.mem_to_reg = 1'b1;
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_MEMWR: begin
        cw.iord       = 1'b1;
        cw.mem_write  = 1'b1;
        cw.instr_done = 1'b1;
        cw.mem_gate   = 1'b1;
      end
      S_EXECUTE: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REG;
        cw.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        cw.reg_dst    = 1'b1;
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a  = 1'b1;
        cw.alu_src_b  = SRCB_REG;
        cw.alu_op     = ALUOP_SUB;
        cw.pc_src     = PCSRC_ALUOUT;
        cw.branch     = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_JUMP: begin
        cw.pc_src     = PCSRC_JUMP;
        cw.pc_write   = 1'b1;
        cw.instr_done = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - multicycle MIPS main control FSM with memory-ready waits
module multicycle_main_control #(
  parameter int MEM_WAIT_EN = 1
) (
  input logic                         clk,
  input logic                         reset,
  multicycle_main_control_if.master   ctrl
);

  import mips_ctrl_pkg::*;

  state_t     state_q;
  state_t     state_d;
  ctrl_word_t cw_raw;
  ctrl_word_t cw_out;
  logic       rdy;
  logic       illegal;

  assign rdy = (MEM_WAIT_EN != 0) ? ctrl.mem_ready : 1'b1;

  mc_ctrl_decode u_decode (
    .state (state_q),
    .cw    (cw_raw)
  );

  // State register: reset always lands in FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: memory states hold until rdy, DECODE and MEMADR branch on opcode
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ctrl.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (ctrl.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = rdy ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output qualification: memory-gated side effects follow rdy, reset blanks everything
  always_comb begin
    cw_out  = cw_raw;
    illegal = (state_q == S_DECODE) && !is_known_opcode(ctrl.opcode);
    if (cw_raw.mem_gate) begin
      cw_out.pc_write   = cw_raw.pc_write & rdy;
      cw_out.ir_write   = cw_raw.ir_write & rdy;
      cw_out.instr_done = cw_raw.instr_done & rdy;
    end
    if (reset) begin
      cw_out  = '0;
      illegal = 1'b0;
    end
  end

  assign ctrl.pc_write   = cw_out.pc_write;
  assign ctrl.branch     = cw_out.branch;
  assign ctrl.iord       = cw_out.iord;
  assign ctrl.mem_write  = cw_out.mem_write;
  assign ctrl.ir_write   = cw_out.ir_write;
  assign ctrl.reg_dst    = cw_out.reg_dst;
  assign ctrl.mem_to_reg = cw_out.mem_to_reg;
  assign ctrl.reg_write  = cw_out.reg_write;
  assign ctrl.alu_src_a  = cw_out.alu_src_a;
  assign ctrl.alu_src_b  = cw_out.alu_src_b;
  assign ctrl.alu_op     = cw_out.alu_op;
  assign ctrl.pc_src     = cw_out.pc_src;
  assign ctrl.instr_done = cw_out.instr_done;
  assign ctrl.illegal_op = illegal;

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - self-checking bench for multicycle_main_control
module tb_multicycle_main_control;

  typedef logic [16:0] vec_t;
  typedef vec_t vec_q_t[$];
  typedef int int_q_t[$];

  // Instruction steps as the specification names them
  localparam int ST_F = 0, ST_D = 1, ST_MA = 2, ST_MR = 3, ST_MWB = 4, ST_MW = 5;
  localparam int ST_EX = 6, ST_AWB = 7, ST_BR = 8, ST_AE = 9, ST_IWB = 10, ST_JMP = 11;

  localparam logic [5:0] T_R = 6'b000000, T_J = 6'b000010, T_BEQ = 6'b000100;
  localparam logic [5:0] T_ADDI = 6'b001000, T_LW = 6'b100011, T_SW = 6'b101011;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  multicycle_main_control_if bus ();

  multicycle_main_control #(.MEM_WAIT_EN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  // vec bits: 16 pc_write 15 branch 14 iord 13 mem_write 12 ir_write 11 reg_dst 10 mem_to_reg
  //           9 reg_write 8 src_a 7:6 src_b 5:4 alu_op 3:2 pc_src 1 instr_done 0 illegal_op
  function automatic vec_t mk(input logic pcw, br, iord, mw, irw, rd, m2r, rw, sa,
                              input logic [1:0] sb, aop, ps, input logic done, ill);
    return {pcw, br, iord, mw, irw, rd, m2r, rw, sa, sb, aop, ps, done, ill};
  endfunction

  function automatic logic known(input logic [5:0] op);
    return op inside {T_R, T_J, T_BEQ, T_ADDI, T_LW, T_SW};
  endfunction

  function automatic vec_t expect_vec(input int step, input logic rdy, input logic [5:0] op);
    case (step)
      ST_F:   return mk(rdy,0,0,0,rdy,0,0,0,0, 2'b01,2'b00,2'b00, 0,0);
      ST_D:   return mk(0,0,0,0,0,0,0,0,0, 2'b11,2'b00,2'b00, 0, !known(op));
      ST_MA:  return mk(0,0,0,0,0,0,0,0,1, 2'b10,2'b00,2'b00, 0,0);
      ST_MR:  return mk(0,0,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0);
      ST_MWB: return mk(0,0,0,0,0,0,1,1,0, 2'b00,2'b00,2'b00, 1,0);
      ST_MW:  return mk(0,0,1,1,0,0,0,0,0, 2'b00,2'b00,2'b00, rdy,0);
      ST_EX:  return mk(0,0,0,0,0,0,0,0,1, 2'b00,2'b10,2'b00, 0,0);
      ST_AWB: return mk(0,0,0,0,0,1,0,1,0, 2'b00,2'b00,2'b00, 1,0);
      ST_BR:  return mk(0,1,0,0,0,0,0,0,1, 2'b00,2'b01,2'b01, 1,0);
      ST_AE:  return mk(0,0,0,0,0,0,0,0,1, 2'b10,2'b00,2'b00, 0,0);
      ST_IWB: return mk(0,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b00, 1,0);
      ST_JMP: return mk(1,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b10, 1,0);
      default: return '0;
    endcase
  endfunction

  function automatic int_q_t seq_of(input logic [5:0] op);
    int_q_t q;
    q.push_back(ST_F);
    q.push_back(ST_D);
    case (op)
      T_LW:   begin q.push_back(ST_MA); q.push_back(ST_MR); q.push_back(ST_MWB); end
      T_SW:   begin q.push_back(ST_MA); q.push_back(ST_MW); end
      T_R:    begin q.push_back(ST_EX); q.push_back(ST_AWB); end
      T_BEQ:  q.push_back(ST_BR);
      T_ADDI: begin q.push_back(ST_AE); q.push_back(ST_IWB); end
      T_J:    q.push_back(ST_JMP);
      default: ;
    endcase
    return q;
  endfunction

  function automatic int latency_of(input logic [5:0] op);
    case (op)
      T_LW: return 5;
      T_SW, T_R, T_ADDI: return 4;
      T_BEQ, T_J: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic is_wait(input int s);
    return (s == ST_F) || (s == ST_MR) || (s == ST_MW);
  endfunction

  function automatic int first_done(input vec_q_t q);
    for (int i = 0; i < q.size(); i++) if (q[i][1]) return i;
    return -1;
  endfunction

  task automatic cycle(input logic [5:0] op, input logic rdy, input logic rst, output vec_t obs);
    @(negedge clk);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    reset         = rst;
    #1;
    obs = {bus.pc_write, bus.branch, bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst,
           bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
           bus.pc_src, bus.instr_done, bus.illegal_op};
  endtask

  // Runs one instruction; collects observed and model-expected vectors, no judging here
  task automatic exec_instr(input logic [5:0] op, input int low_step, input int low_n,
                            input int rand_pct, output vec_q_t obs_q, output vec_q_t exp_q,
                            output int waits);
    int_q_t seq;
    int     idx;
    int     lows;
    logic   rdy;
    vec_t   o;
    seq = seq_of(op);
    idx = 0;
    lows = 0;
    waits = 0;
    obs_q.delete();
    exp_q.delete();
    while (idx < seq.size()) begin
      if (is_wait(seq[idx])) begin
        rdy = 1'b1;
        if (seq[idx] == low_step && lows < low_n) begin
          rdy = 1'b0;
          lows++;
        end else if (rand_pct > 0 && int'($urandom_range(99)) < rand_pct) begin
          rdy = 1'b0;
        end
      end else begin
        rdy = (rand_pct > 0) ? 1'($urandom_range(1)) : 1'b1;
      end
      cycle(op, rdy, 1'b0, o);
      obs_q.push_back(o);
      exp_q.push_back(expect_vec(seq[idx], rdy, op));
      if (is_wait(seq[idx]) && !rdy) waits++;
      else idx++;
    end
  endtask

  task automatic test_reset();
    vec_t o;
    vec_t e;
    for (int i = 0; i < 3; i++) begin
      cycle(T_J, 1'b1, 1'b1, o);
      n_cmp++;
      if (o !== '0) begin n_bad++; $display("FAIL reset_hold cyc%0d: got %05h want 00000", i, o); end
    end
    cycle(T_J, 1'b1, 1'b0, o);
    e = expect_vec(ST_F, 1'b1, T_J);
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL reset_first_fetch: got %05h want %05h", o, e); end
    n_cmp++;
    if ({o[16], o[12]} !== 2'b11) begin n_bad++; $display("FAIL reset_pcw_irw: got %b want 11", {o[16], o[12]}); end
    cycle(T_J, 1'b0, 1'b0, o);
    e = expect_vec(ST_D, 1'b0, T_J);
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL reset_decode: got %05h want %05h", o, e); end
    cycle(T_J, 1'b0, 1'b0, o);
    e = expect_vec(ST_JMP, 1'b0, T_J);
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL reset_jump: got %05h want %05h", o, e); end
  endtask

  task automatic test_lw();
    vec_q_t ob, ex;
    int w;
    exec_instr(T_LW, -1, 0, 0, ob, ex, w);
    for (int i = 0; i < ob.size(); i++) begin
      n_cmp++;
      if (ob[i] !== ex[i]) begin n_bad++; $display("FAIL lw cyc%0d: got %05h want %05h", i, ob[i], ex[i]); end
    end
    n_cmp++;
    if (first_done(ob) != 4) begin n_bad++; $display("FAIL lw_done_cycle: got %0d want 4", first_done(ob)); end
    n_cmp++;
    if ({ob[4][10], ob[4][9]} !== 2'b11) begin n_bad++; $display("FAIL lw_wb: got %b want 11", {ob[4][10], ob[4][9]}); end
  endtask

  task automatic test_sw_wait();
    vec_q_t ob, ex;
    int w;
    int mw;
    exec_instr(T_SW, ST_MW, 2, 0, ob, ex, w);
    mw = 0;
    for (int i = 0; i < ob.size(); i++) begin
      n_cmp++;
      if (ob[i] !== ex[i]) begin n_bad++; $display("FAIL sw cyc%0d: got %05h want %05h", i, ob[i], ex[i]); end
      if (ob[i][13]) mw++;
    end
    n_cmp++;
    if (mw != 3) begin n_bad++; $display("FAIL sw_mem_write_cycles: got %0d want 3", mw); end
    n_cmp++;
    if (first_done(ob) != 5) begin n_bad++; $display("FAIL sw_done_cycle: got %0d want 5", first_done(ob)); end
  endtask

  task automatic test_r_beq();
    vec_q_t ob, ex;
    int w;
    exec_instr(T_R, -1, 0, 0, ob, ex, w);
    for (int i = 0; i < ob.size(); i++) begin
      n_cmp++;
      if (ob[i] !== ex[i]) begin n_bad++; $display("FAIL rtype cyc%0d: got %05h want %05h", i, ob[i], ex[i]); end
    end
    n_cmp++;
    if (ob[2][5:4] !== 2'b10 || ob[3][11] !== 1'b1) begin
      n_bad++; $display("FAIL rtype_aluop_regdst: got %b/%b want 10/1", ob[2][5:4], ob[3][11]);
    end
    n_cmp++;
    if (first_done(ob) != 3) begin n_bad++; $display("FAIL rtype_latency: got %0d want 3", first_done(ob)); end
    exec_instr(T_BEQ, -1, 0, 0, ob, ex, w);
    for (int i = 0; i < ob.size(); i++) begin
      n_cmp++;
      if (ob[i] !== ex[i]) begin n_bad++; $display("FAIL beq cyc%0d: got %05h want %05h", i, ob[i], ex[i]); end
    end
    n_cmp++;
    if ({ob[2][5:4], ob[2][15], ob[2][3:2]} !== 5'b01101) begin
      n_bad++; $display("FAIL beq_branch: got %b want 01101", {ob[2][5:4], ob[2][15], ob[2][3:2]});
    end
    n_cmp++;
    if (first_done(ob) != 2) begin n_bad++; $display("FAIL beq_latency: got %0d want 2", first_done(ob)); end
  endtask

  task automatic test_addi_j();
    vec_q_t ob, ex;
    int w;
    exec_instr(T_ADDI, -1, 0, 0, ob, ex, w);
    for (int i = 0; i < ob.size(); i++) begin
      n_cmp++;
      if (ob[i] !== ex[i]) begin n_bad++; $display("FAIL addi cyc%0d: got %05h want %05h", i, ob[i], ex[i]); end
    end
    n_cmp++;
    if ({ob[2][7:6], ob[3][9], ob[3][11]} !== 4'b1010) begin
      n_bad++; $display("FAIL addi_fields: got %b want 1010", {ob[2][7:6], ob[3][9], ob[3][11]});
    end
    exec_instr(T_J, -1, 0, 0, ob, ex, w);
    for (int i = 0; i < ob.size(); i++) begin
      n_cmp++;
      if (ob[i] !== ex[i]) begin n_bad++; $display("FAIL jump cyc%0d: got %05h want %05h", i, ob[i], ex[i]); end
    end
    n_cmp++;
    if ({ob[2][3:2], ob[2][16]} !== 3'b101) begin
      n_bad++; $display("FAIL jump_fields: got %b want 101", {ob[2][3:2], ob[2][16]});
    end
  endtask

  task automatic test_illegal();
    vec_q_t ob, ex;
    int w;
    int ill;
    vec_t o;
    vec_t e;
    exec_instr(6'b111111, -1, 0, 0, ob, ex, w);
    ill = 0;
    for (int i = 0; i < ob.size(); i++) begin
      n_cmp++;
      if (ob[i] !== ex[i]) begin n_bad++; $display("FAIL illegal cyc%0d: got %05h want %05h", i, ob[i], ex[i]); end
      if (ob[i][0]) ill++;
    end
    n_cmp++;
    if (ill != 1) begin n_bad++; $display("FAIL illegal_pulses: got %0d want 1", ill); end
    cycle(6'b111111, 1'b0, 1'b0, o);
    e = expect_vec(ST_F, 1'b0, 6'b111111);
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL illegal_refetch: got %05h want %05h", o, e); end
    cycle(T_LW, 1'b1, 1'b0, o);
    n_cmp++;
    if (o !== expect_vec(ST_F, 1'b1, T_LW)) begin n_bad++; $display("FAIL illegal_refetch2: got %05h", o); end
    cycle(T_LW, 1'b1, 1'b0, o);
    cycle(T_LW, 1'b1, 1'b0, o);
    cycle(T_LW, 1'b1, 1'b0, o);
    cycle(T_LW, 1'b1, 1'b0, o);
    n_cmp++;
    if (o !== expect_vec(ST_MWB, 1'b1, T_LW)) begin n_bad++; $display("FAIL illegal_followup_lw: got %05h", o); end
  endtask

  task automatic test_reset_mid();
    vec_t o;
    int   steps[4];
    cycle(T_LW, 1'b1, 1'b0, o);
    cycle(T_LW, 1'b1, 1'b0, o);
    cycle(T_LW, 1'b1, 1'b0, o);
    cycle(T_LW, 1'b0, 1'b0, o);
    n_cmp++;
    if (o !== expect_vec(ST_MR, 1'b0, T_LW)) begin n_bad++; $display("FAIL rmid_memrd: got %05h", o); end
    cycle(T_LW, 1'b1, 1'b1, o);
    n_cmp++;
    if (o !== '0) begin n_bad++; $display("FAIL rmid_reset_cycle: got %05h want 00000", o); end
    cycle(T_LW, 1'b1, 1'b0, o);
    n_cmp++;
    if (o !== expect_vec(ST_F, 1'b1, T_LW)) begin n_bad++; $display("FAIL rmid_fetch: got %05h want %05h", o, expect_vec(ST_F, 1'b1, T_LW)); end
    steps = '{ST_D, ST_MA, ST_MR, ST_MWB};
    for (int i = 0; i < 4; i++) begin
      cycle(T_LW, 1'b1, 1'b0, o);
      n_cmp++;
      if (o !== expect_vec(steps[i], 1'b1, T_LW)) begin
        n_bad++; $display("FAIL rmid_resume%0d: got %05h want %05h", i, o, expect_vec(steps[i], 1'b1, T_LW));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[7];
    logic [5:0] op;
    vec_q_t ob, ex;
    int w;
    int bad_here;
    ops = '{T_R, T_J, T_BEQ, T_ADDI, T_LW, T_SW, 6'b010101};
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(6)];
      if (op == 6'b010101) op = 6'($urandom_range(63));
      exec_instr(op, -1, 0, 30, ob, ex, w);
      bad_here = 0;
      for (int i = 0; i < ob.size(); i++) begin
        n_cmp++;
        if (ob[i] !== ex[i]) begin
          n_bad++; bad_here++;
          if (bad_here < 3) $display("FAIL rand%0d op%b cyc%0d: got %05h want %05h", n, op, i, ob[i], ex[i]);
        end
      end
      if (known(op)) begin
        n_cmp++;
        if (first_done(ob) != latency_of(op) - 1 + w) begin
          n_bad++; $display("FAIL rand%0d_latency op%b: got %0d want %0d", n, op, first_done(ob), latency_of(op) - 1 + w);
        end
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.opcode    = '0;
    bus.mem_ready = 1'b1;
    test_reset();
    test_lw();
    test_sw_wait();
    test_r_beq();
    test_addi_j();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
